// File: rtl/prospero_ocl_eval.sv
// AXI-Lite (OCL) front-end for the prospero evaluation circuit: operand registers,
// launch admission against a result FIFO, and capture of fixed-latency results.
module prospero_ocl_eval #(
  parameter int WIDTH      = 64,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_main_a0,
  input  logic             rst_main_n,
  input  logic [31:0]      ocl_cl_awaddr,
  input  logic             ocl_cl_awvalid,
  output logic             cl_ocl_awready,
  input  logic [31:0]      ocl_cl_wdata,
  input  logic [3:0]       ocl_cl_wstrb,
  input  logic             ocl_cl_wvalid,
  output logic             cl_ocl_wready,
  output logic [1:0]       cl_ocl_bresp,
  output logic             cl_ocl_bvalid,
  input  logic             ocl_cl_bready,
  input  logic [31:0]      ocl_cl_araddr,
  input  logic             ocl_cl_arvalid,
  output logic             cl_ocl_arready,
  output logic [31:0]      cl_ocl_rdata,
  output logic [1:0]       cl_ocl_rresp,
  output logic             cl_ocl_rvalid,
  input  logic             ocl_cl_rready,
  output logic [WIDTH-1:0] eval_x,
  output logic [WIDTH-1:0] eval_y,
  output logic             eval_valid,
  input  logic [WIDTH-1:0] eval_out
);
  localparam int NW = WIDTH / 32;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             rst_done;
  logic             aw_full, w_full;
  logic [7:0]       aw_addr;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [WIDTH-1:0] x_reg, y_reg;
  logic [31:0]      launch_cnt;
  logic             overflow;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, inflight, count_base;
  logic [CW:0]      occupancy;
  logic [PIPE_LAT-1:0] valid_sr;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{ocl_cl_awaddr[31:8], ocl_cl_araddr[31:8]};

  // Ready gated by rst_done so all handshake outputs are low while in reset.
  assign cl_ocl_awready = rst_done & ~aw_full & ~cl_ocl_bvalid;
  assign cl_ocl_wready  = rst_done & ~w_full & ~cl_ocl_bvalid;
  assign cl_ocl_arready = rst_done & ~cl_ocl_rvalid;

  logic [2:0] wr_idx;
  logic wr_x, wr_y, wr_ctrl, wr_status, wr_ok, commit;
  logic launch_req, flush, pop_ok, push, admit, launch_ok;

  assign wr_idx    = aw_addr[4:2];
  assign wr_x      = (aw_addr[1:0] == 2'b00) && (aw_addr[7:5] == 3'd0) && (int'(wr_idx) < NW);
  assign wr_y      = (aw_addr[1:0] == 2'b00) && (aw_addr[7:5] == 3'd1) && (int'(wr_idx) < NW);
  assign wr_ctrl   = (aw_addr == 8'h40);
  assign wr_status = (aw_addr == 8'h44);
  assign wr_ok     = wr_x | wr_y | wr_ctrl | wr_status;
  assign commit    = aw_full & w_full & ~cl_ocl_bvalid;

  assign launch_req = commit & wr_ctrl & w_strb[0] & w_data[0];
  assign flush      = commit & wr_ctrl & w_strb[0] & w_data[1];
  assign pop_ok     = commit & wr_ctrl & w_strb[0] & w_data[2] & ~w_data[1] & (count != '0);
  assign push       = valid_sr[PIPE_LAT-1];

  // Admission sees the FIFO after this write's flush/pop; a concurrent push moves one
  // entry from inflight to count, leaving the sum unchanged.
  assign count_base = flush ? '0 : (pop_ok ? count - CW'(1) : count);
  assign occupancy  = {1'b0, count_base} + {1'b0, inflight};
  assign admit      = occupancy < (CW+1)'(FIFO_DEPTH);
  assign launch_ok  = launch_req & admit;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      rst_done      <= 1'b0;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      cl_ocl_bvalid <= 1'b0;
      cl_ocl_bresp  <= 2'b00;
    end else begin
      rst_done <= 1'b1;
      if (ocl_cl_awvalid && cl_ocl_awready) begin
        aw_full <= 1'b1;
        aw_addr <= ocl_cl_awaddr[7:0];
      end
      if (ocl_cl_wvalid && cl_ocl_wready) begin
        w_full <= 1'b1;
        w_data <= ocl_cl_wdata;
        w_strb <= ocl_cl_wstrb;
      end
      if (commit) begin
        cl_ocl_bvalid <= 1'b1;
        cl_ocl_bresp  <= wr_ok ? 2'b00 : 2'b10;
      end else if (cl_ocl_bvalid && ocl_cl_bready) begin
        cl_ocl_bvalid <= 1'b0;
        aw_full       <= 1'b0;
        w_full        <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      x_reg      <= '0;
      y_reg      <= '0;
      overflow   <= 1'b0;
      launch_cnt <= '0;
      eval_x     <= '0;
      eval_y     <= '0;
      eval_valid <= 1'b0;
      count      <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid_sr   <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (commit && int'(wr_idx) == i && w_strb[b]) begin
            if (wr_x) x_reg[i*32 + b*8 +: 8] <= w_data[b*8 +: 8];
            if (wr_y) y_reg[i*32 + b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
      if (launch_req && !admit) overflow <= 1'b1;
      else if (commit && wr_status && w_strb[1] && w_data[10]) overflow <= 1'b0;

      eval_valid <= launch_ok;
      if (launch_ok) begin
        eval_x     <= x_reg;
        eval_y     <= y_reg;
        launch_cnt <= launch_cnt + 32'd1;
      end
      valid_sr <= PIPE_LAT'({valid_sr, eval_valid});

      if (launch_ok && !push) inflight <= inflight + CW'(1);
      else if (!launch_ok && push) inflight <= inflight - CW'(1);

      // Flush takes effect before a same-cycle push, so an arriving result survives it.
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= push ? CW'(1) : '0;
      end else begin
        if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop_ok) count <= count + CW'(1);
        else if (!push && pop_ok) count <= count - CW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (push) mem[wr_ptr] <= eval_out;
  end

  logic [7:0]       ra;
  logic [WIDTH-1:0] head;
  logic [31:0]      rd_data_n;
  logic [1:0]       rd_resp_n;

  assign ra   = ocl_cl_araddr[7:0];
  assign head = mem[rd_ptr];

  always_comb begin
    rd_data_n = 32'hDEAD_BEEF;
    rd_resp_n = 2'b10;
    if (ra[1:0] == 2'b00) begin
      for (int i = 0; i < NW; i++) begin
        if (int'(ra[4:2]) == i) begin
          if (ra[7:5] == 3'd0) begin rd_data_n = x_reg[i*32 +: 32]; rd_resp_n = 2'b00; end
          if (ra[7:5] == 3'd1) begin rd_data_n = y_reg[i*32 +: 32]; rd_resp_n = 2'b00; end
          if (ra[7:5] == 3'd3) begin
            rd_data_n = (count == '0) ? 32'd0 : head[i*32 +: 32];
            rd_resp_n = 2'b00;
          end
        end
      end
      case (ra)
        8'h40: begin rd_data_n = 32'd0; rd_resp_n = 2'b00; end
        8'h44: begin
          rd_data_n = {20'd0, inflight != '0, overflow, count == CW'(FIFO_DEPTH),
                       count == '0, 8'(count)};
          rd_resp_n = 2'b00;
        end
        8'h48: begin rd_data_n = launch_cnt; rd_resp_n = 2'b00; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      cl_ocl_rvalid <= 1'b0;
      cl_ocl_rdata  <= '0;
      cl_ocl_rresp  <= 2'b00;
    end else if (ocl_cl_arvalid && cl_ocl_arready) begin
      cl_ocl_rvalid <= 1'b1;
      cl_ocl_rdata  <= rd_data_n;
      cl_ocl_rresp  <= rd_resp_n;
    end else if (cl_ocl_rvalid && ocl_cl_rready) begin
      cl_ocl_rvalid <= 1'b0;
    end
  end
endmodule

// File: doc/prospero_ocl_eval.md
# prospero_ocl_eval

- Parametrised AXI-Lite (OCL) front-end for the prospero evaluation circuit.
- Holds WIDTH-bit x/y operand registers and launches evaluations into a fixed-latency pipelined circuit.
- Captures each result into a FIFO that the host drains.
- Full AXI-Lite handshakes, including back-pressure on B and R.
- Sits between the shell OCL port and circuit_wrapper inside the prospero top.

## Interface
- WIDTH, 64: operand/result width. Must be a multiple of 32, at most 256. NW = WIDTH/32 words.
- PIPE_LAT, 4: circuit latency in cycles from eval_valid to a valid eval_out. Must be at least 1.
- FIFO_DEPTH, 8: result FIFO depth. Must be a power of 2, at most 128.

Ports:
- clk_main_a0  in  1  clock.
- rst_main_n  in  1  one clock; reset is asynchronous and active-low.
- ocl_cl_awaddr  in  32  write address. Only bits [7:0] are decoded.
- ocl_cl_awvalid  in  1 / cl_ocl_awready  out  1.
- ocl_cl_wdata  in  32 / ocl_cl_wstrb  in  4 / ocl_cl_wvalid  in  1 / cl_ocl_wready  out  1.
- cl_ocl_bresp  out  2 / cl_ocl_bvalid  out  1 / ocl_cl_bready  in  1.
- ocl_cl_araddr  in  32 / ocl_cl_arvalid  in  1 / cl_ocl_arready  out  1.
- cl_ocl_rdata  out  32 / cl_ocl_rresp  out  2 / cl_ocl_rvalid  out  1 / ocl_cl_rready  in  1.
- eval_x, eval_y  out  WIDTH  operands driven to the circuit.
- eval_valid  out  1  one-cycle launch strobe.
- eval_out  in  WIDTH  circuit result.

## Operation
Register map (byte address):
- 0x00+4i: X word i (i<NW), RW.
- 0x20+4i: Y word i, RW.
- 0x40 CTRL, write-only; reads return 0.
  - bit0 launch; bit1 flush FIFO; bit2 pop FIFO head.
  - CTRL actions fire only if wstrb[0]=1.
- 0x44 STATUS, RO except bit10.
  - [7:0] FIFO count; bit8 empty; bit9 full.
  - bit10 sticky overflow, write-1-to-clear.
  - bit11 in-flight nonzero.
- 0x48 LAUNCH_CNT, RO. 32-bit count of accepted launches, wraps.
- 0x60+4i: RESULT word i of the FIFO head, RO, no side effect. Reads 0 when empty.

Write channel:
- AW and W are accepted independently and latched.
  - awready = no AW latched and bvalid low.
  - wready = no W latched and bvalid low.
- The commit cycle is the first cycle both AW and W are latched.
  - The register update happens at that edge.
  - bvalid rises the next cycle and holds until bready; the latches then clear.
- X/Y writes honour wstrb per byte.
- An unmapped or RO address gets bresp=SLVERR (2'b10) and no state change. STATUS bit10 clear is OKAY.

Read channel:
- arready = !rvalid.
- On AR handshake, rdata/rresp are registered and rvalid is asserted the next cycle.
- rvalid holds with rdata stable until rready.
- An unmapped address returns 0xDEADBEEF with SLVERR.

Launch:
- A launch is accepted iff count + inflight < FIFO_DEPTH. inflight is the number of launches not yet captured.
- Accepted: eval_x/eval_y load from X/Y, eval_valid pulses, LAUNCH_CNT increments.
- Refused: sets overflow; no pulse, no count.

Capture:
- A PIPE_LAT-deep valid shift register tracks launches.
- Its output pushes eval_out into the FIFO.
- Because admission reserves a slot, a push never sees the FIFO full.

Same-write combinations:
- Flush resets FIFO count to 0; in-flight results still arrive and push afterwards.
- Flush and pop in the same write: flush only.
- Flush and launch in the same write: flush first, then the launch is evaluated against the new count.
- Pop when empty is ignored.
- Pop and push in the same cycle: count unchanged, head advances.

## Timing
- Reset values:
  - All ready/valid outputs 0; bresp/rresp 0; rdata 0.
  - eval_x, eval_y, eval_valid 0.
  - X, Y, FIFO pointers/count, overflow, LAUNCH_CNT, shift register all 0.
- Reset asserted mid-transaction discards latched AW/W and pending B/R responses; no response is issued after release.
- Write latency: commit at edge C; bvalid in cycle C+1.
- Launch: commit at C; eval_valid high in cycle C+1 with eval_x/eval_y stable from C+1 until the next launch.
- Capture: eval_out is sampled in cycle C+1+PIPE_LAT. STATUS count reflects it from C+2+PIPE_LAT.
- Back-to-back launches are allowed every write commit; the pipeline is fully pipelined.
- Read latency: AR handshake at A; rvalid in A+1. A STATUS read reflects state as of edge A.

## Test plan
- Reset, then read 0x44 -> rdata 0x00000100 (empty), OKAY; read 0x48 -> 0.
- WIDTH=64, PIPE_LAT=4: write X = 0x1_00000000, Y = 0x2_00000000, CTRL = 1 -> eval_valid exactly one cycle. Model returns x+y. Read 0x60 / 0x64 -> 0x00000000 / 0x00000003; STATUS count 1.
- FIFO_DEPTH=8: issue 9 launches without pop -> 8 results. STATUS = 0x208 plus bit10. Write 0x400 to STATUS -> bit10 cleared. LAUNCH_CNT = 8.
- Hold bready=0 for 10 cycles after a write -> bvalid stays high, awready/wready stay low. Hold rready=0 likewise -> rdata is stable.
- Issue a launch, then flush+pop (CTRL = 6) while the launch is in flight -> count 0 after flush, 1 after the in-flight result arrives.
- Read 0x30, write 0x7C -> rdata 0xDEADBEEF with rresp 2'b10; bresp 2'b10 and no register changes.
